// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory stage and its helpers:
//   access-size encodings, the stage state enum, and the byte-enable,
//   store-lane and alignment helpers used at request time.
package mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // Byte enables for an access of the given size at byte offset addr_lo.
   function automatic logic [3:0] lane_be(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr_lo;
         SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across every lane so the memory can pick by be.
   function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                              input logic [31:0] d);
      logic [31:0] w;
      case (size)
         SZ_BYTE: w = {4{d[7:0]}};
         SZ_HALF: w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] addr_lo);
      logic m;
      case (size)
         SZ_BYTE: m = 1'b0;
         SZ_HALF: m = addr_lo[0];
         default: m = (addr_lo != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align
//   Combinational load formatter: picks the addressed byte/half out of a
//   32-bit read word and zero- or sign-extends it to 32 bits.
//   Ports:
//     rdata      in  32  raw read word
//     addr_lo    in  2   byte offset of the access
//     size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//     is_signed  in  1   sign-extend narrow loads
//     load_data  out 32  extended result
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = 8'h00;
      half_sel  = 16'h0000;
      load_data = 32'h0;
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: load_data = is_signed ? {{24{byte_sel[7]}}, byte_sel}
                                        : {24'h0, byte_sel};
         SZ_HALF: load_data = is_signed ? {{16{half_sel[15]}}, half_sel}
                                        : {16'h0, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Pipeline stage after execute. Registers the execute result, performs at
//   most one data-memory load/store per instruction over a req/ack handshake,
//   formats load data and retires one result per instruction to writeback.
//   Upstream is stalled while a transaction is outstanding; a transaction
//   with no ack for ACK_TIMEOUT cycles is aborted with a fault.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for an instruction; non-memory ops retire next cycle
//   ST_WAIT | dmem request outstanding, waiting for ack or timeout
//
//   Ports:
//     clk, resetn                     clock, async active-low reset
//     ex_*                            instruction from execute (valid/ready)
//     dmem_req/we/addr/wdata/be       registered memory request
//     dmem_ack, dmem_rdata            same-cycle completion and read data
//     wb_valid/wen/rd/data            registered retire to writeback
//     mem_fault                       pulse on misalignment or timeout
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = 64,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_data,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_wen,
   input  logic        ex_mem_rd,
   input  logic        ex_mem_wr,
   input  logic [1:0]  ex_size,
   input  logic        ex_signed,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_wen,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_fault
);

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(ACK_TIMEOUT);
   localparam bit               TMO_EN    = (ACK_TIMEOUT != 0);

   state_e            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              ready_q,  ready_d;
   logic              req_q,    req_d;
   logic              we_q,     we_d;
   logic [31:0]       addr_q,   addr_d;
   logic [31:0]       wdata_q,  wdata_d;
   logic [3:0]        be_q,     be_d;
   logic [4:0]        rd_q,     rd_d;
   logic              rwen_q,   rwen_d;
   logic              load_q,   load_d;
   logic [1:0]        size_q,   size_d;
   logic              sgn_q,    sgn_d;
   logic [1:0]        alo_q,    alo_d;
   logic              wbv_q,    wbv_d;
   logic              wbw_q,    wbw_d;
   logic [4:0]        wbrd_q,   wbrd_d;
   logic [31:0]       wbdat_q,  wbdat_d;
   logic              fault_q,  fault_d;

   logic [31:0]       load_data;
   logic              accept;
   logic              is_mem;
   logic              timeout_hit;

   mem_load_align u_align (
      .rdata     (dmem_rdata),
      .addr_lo   (alo_q),
      .size      (size_q),
      .is_signed (sgn_q),
      .load_data (load_data)
   );

   assign accept = ex_valid && ready_q && (state_q == ST_IDLE);
   assign is_mem = ex_mem_rd || ex_mem_wr;
   // Timeout fires on the edge where the WAIT-cycle count would reach the limit.
   assign timeout_hit = TMO_EN && ((cnt_q + CNT_W'(1)) == TMO_LIMIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rd_d    = rd_q;
      rwen_d  = rwen_q;
      load_d  = load_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      alo_d   = alo_q;
      wbv_d   = 1'b0;
      wbw_d   = 1'b0;
      fault_d = 1'b0;
      wbrd_d  = wbrd_q;
      wbdat_d = wbdat_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  wbv_d   = 1'b1;
                  wbw_d   = ex_reg_wen;
                  wbrd_d  = ex_rd;
                  wbdat_d = ex_data;
               end else if (misaligned(ex_size, ex_data[1:0])) begin
                  wbv_d   = 1'b1;
                  wbrd_d  = ex_rd;
                  fault_d = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
                  we_d    = ex_mem_wr;
                  addr_d  = {ex_data[31:2], 2'b00};
                  wdata_d = lane_wdata(ex_size, ex_store_data);
                  be_d    = lane_be(ex_size, ex_data[1:0]);
                  rd_d    = ex_rd;
                  rwen_d  = ex_reg_wen;
                  load_d  = ex_mem_rd;
                  size_d  = ex_size;
                  sgn_d   = ex_signed;
                  alo_d   = ex_data[1:0];
               end
            end
         end
         ST_WAIT: begin
            if (dmem_ack) begin
               state_d = ST_IDLE;
               wbv_d   = 1'b1;
               wbrd_d  = rd_q;
               wbw_d   = load_q && rwen_q;
               wbdat_d = load_q ? load_data : 32'h0;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
               wbv_d   = 1'b1;
               wbrd_d  = rd_q;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      req_d   = (state_d == ST_WAIT);
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         rd_q    <= 5'h0;
         rwen_q  <= 1'b0;
         load_q  <= 1'b0;
         size_q  <= SZ_BYTE;
         sgn_q   <= 1'b0;
         alo_q   <= 2'b00;
         wbv_q   <= 1'b0;
         wbw_q   <= 1'b0;
         wbrd_q  <= 5'h0;
         wbdat_q <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         rwen_q  <= rwen_d;
         load_q  <= load_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         alo_q   <= alo_d;
         wbv_q   <= wbv_d;
         wbw_q   <= wbw_d;
         wbrd_q  <= wbrd_d;
         wbdat_q <= wbdat_d;
         fault_q <= fault_d;
      end
   end

   assign ex_ready   = ready_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;
   assign wb_valid   = wbv_q;
   assign wb_wen     = wbw_q;
   assign wb_rd      = wbrd_q;
   assign wb_data    = wbdat_q;
   assign mem_fault  = fault_q;

endmodule
